// File: rtl/button_pkg.sv
// Shared types and counter-width helpers for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  localparam int DEF_WIDTH           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed for a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Board-side button bundle: raw pins in, conditioned level and pulses out.
interface button_conditioner_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] BtnRaw;
  logic [WIDTH-1:0] BtnLevel;
  logic [WIDTH-1:0] BtnPress;
  logic [WIDTH-1:0] BtnRelease;

  modport master (output BtnRaw, input BtnLevel, input BtnPress, input BtnRelease);
  modport slave  (input BtnRaw, output BtnLevel, output BtnPress, output BtnRelease);
endinterface

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// pulse generation and an optional hold-to-repeat FSM.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RC_W = max_int(cnt_width(REPEAT_DELAY), cnt_width(REPEAT_PERIOD));

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic [DB_W-1:0] cnt_q;
  logic            release_q;
  logic            press_q;
  logic [RC_W-1:0] rcnt_q;
  repeat_state_t   state_q;

  logic cnt_done_s;
  logic accept_s;
  logic rise_s;
  logic fall_s;

  assign cnt_done_s = (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign accept_s   = (sync2_q != stable_q) && cnt_done_s;
  assign rise_s     = accept_s && sync2_q;
  assign fall_s     = accept_s && !sync2_q;

  // Synchronise the pin and accept a new level only after a full quiet run.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      release_q <= fall_s;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_done_s) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  // Press pulse plus auto-repeat; a release accepted this cycle wins over any repeat.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= rise_s;
      if (!REPEAT_EN) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            rcnt_q <= '0;
            if (rise_s) begin
              state_q <= DELAY;
            end else begin
              state_q <= IDLE;
            end
          end
          DELAY: begin
            if (!stable_q || fall_s) begin
              state_q <= IDLE;
              rcnt_q  <= '0;
            end else if (rcnt_q == RC_W'(REPEAT_DELAY - 1)) begin
              press_q <= 1'b1;
              rcnt_q  <= '0;
              state_q <= REPEAT;
            end else begin
              rcnt_q <= rcnt_q + RC_W'(1);
            end
          end
          REPEAT: begin
            if (!stable_q || fall_s) begin
              state_q <= IDLE;
              rcnt_q  <= '0;
            end else if (rcnt_q == RC_W'(REPEAT_PERIOD - 1)) begin
              press_q <= 1'b1;
              rcnt_q  <= '0;
            end else begin
              rcnt_q <= rcnt_q + RC_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            rcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions WIDTH raw board buttons into clean levels and press/release pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int               WIDTH           = DEF_WIDTH,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [WIDTH-1:0] REPEAT_MASK     = 4'b1100
) (
  input logic                  Clk,
  input logic                  Reset,
  button_conditioner_if.slave  btn
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_channel (
      .Clk       (Clk),
      .Reset     (Reset),
      .raw_i     (btn.BtnRaw[i]),
      .level_o   (btn.BtnLevel[i]),
      .press_o   (btn.BtnPress[i]),
      .release_o (btn.BtnRelease[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner against an edge-indexed reference model.
module tb_button_conditioner;

  localparam int         W    = 4;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 5;
  localparam logic [3:0] MASK = 4'b1100;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  button_conditioner_if #(.WIDTH(W)) bif ();

  button_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .btn   (bif)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: raw samples per edge since reset, accepted level, edge of last
  // acceptance and edge of the last accepted press.
  logic [W-1:0] rh[$];
  bit           st[W];
  int           last_acc[W];
  int           press_edge[W];
  logic [W-1:0] exp_level, exp_press, exp_rel;
  int           cnt_press[W];
  int           cnt_rel[W];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronised value seen by the debouncer at edge k: the raw pin two edges earlier.
  function automatic bit s_at(input int k, input int ch);
    return (k >= 2) ? rh[k-2][ch] : 1'b0;
  endfunction

  task automatic model_reset();
    rh.delete();
    for (int ch = 0; ch < W; ch++) begin
      st[ch]         = 1'b0;
      last_acc[ch]   = -1;
      press_edge[ch] = 0;
    end
    exp_level = '0;
    exp_press = '0;
    exp_rel   = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] raw_v);
    int n;
    int d;
    bit acc, rise, fall, rep;
    rh.push_back(raw_v);
    n = rh.size() - 1;
    for (int ch = 0; ch < W; ch++) begin
      // A new level is accepted after DB consecutive differing samples since the last change.
      acc = ((n - last_acc[ch]) >= DB);
      if (acc) begin
        for (int k = n - DB + 1; k <= n; k++) begin
          if (s_at(k, ch) == st[ch]) acc = 1'b0;
        end
      end
      rise = acc && !st[ch];
      fall = acc && st[ch];
      rep  = 1'b0;
      if (MASK[ch] && st[ch] && !fall) begin
        d   = n - press_edge[ch];
        rep = (d == RD) || ((d > RD) && (((d - RD) % RP) == 0));
      end
      if (acc) begin
        st[ch]       = !st[ch];
        last_acc[ch] = n;
      end
      if (rise) press_edge[ch] = n;
      exp_level[ch] = st[ch];
      exp_press[ch] = rise || rep;
      exp_rel[ch]   = fall;
    end
  endtask

  task automatic step(input logic [W-1:0] raw_v, input logic rst_v);
    @(negedge Clk);
    check_eq("level", 32'(bif.BtnLevel), 32'(exp_level));
    check_eq("press", 32'(bif.BtnPress), 32'(exp_press));
    check_eq("release", 32'(bif.BtnRelease), 32'(exp_rel));
    for (int ch = 0; ch < W; ch++) begin
      cnt_press[ch] += int'(bif.BtnPress[ch]);
      cnt_rel[ch]   += int'(bif.BtnRelease[ch]);
    end
    bif.BtnRaw = raw_v;
    if (rst_v) begin
      Reset = 1'b1;
      model_reset();
      #1;
      check_eq("rst_level", 32'(bif.BtnLevel), 32'd0);
      check_eq("rst_press", 32'(bif.BtnPress), 32'd0);
      check_eq("rst_release", 32'(bif.BtnRelease), 32'd0);
    end else begin
      Reset = 1'b0;
      model_edge(raw_v);
    end
  endtask

  initial begin
    logic [W-1:0] rawv;
    int dur[W];
    int rlen;

    model_reset();
    bif.BtnRaw = 4'hF;
    for (int ch = 0; ch < W; ch++) begin
      cnt_press[ch] = 0;
      cnt_rel[ch]   = 0;
    end

    // Reset with all buttons held, then release reset and keep holding.
    repeat (3) step(4'hF, 1'b1);
    repeat (30) step(4'hF, 1'b0);
    repeat (30) step(4'h0, 1'b0);

    // Directed 40-cycle hold on ch1 (no repeat) and ch2 (repeat).
    for (int ch = 0; ch < W; ch++) begin
      cnt_press[ch] = 0;
      cnt_rel[ch]   = 0;
    end
    repeat (40) step(4'b0110, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    check_eq("ch2_press_count", 32'(cnt_press[2]), 32'd7);
    check_eq("ch1_press_count", 32'(cnt_press[1]), 32'd1);
    check_eq("ch2_release_count", 32'(cnt_rel[2]), 32'd1);
    check_eq("ch1_release_count", 32'(cnt_rel[1]), 32'd1);
    check_eq("ch0_press_count", 32'(cnt_press[0]), 32'd0);

    // Reset while ch3 is auto-repeating, button still held afterwards.
    repeat (30) step(4'b1000, 1'b0);
    repeat (2) step(4'b1000, 1'b1);
    repeat (25) step(4'b1000, 1'b0);
    repeat (20) step(4'b0000, 1'b0);

    // Random holds and bounces with occasional resets.
    rawv = '0;
    for (int ch = 0; ch < W; ch++) dur[ch] = $urandom_range(0, 20);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rlen = $urandom_range(1, 3);
        repeat (rlen) step(rawv, 1'b1);
      end
      for (int ch = 0; ch < W; ch++) begin
        if (dur[ch] == 0) begin
          rawv[ch] = ~rawv[ch];
          dur[ch]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 45);
        end else begin
          dur[ch]--;
        end
      end
      step(rawv, 1'b0);
    end
    step(rawv, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
